// File: rtl/mem_stage_hs.sv
// mem_stage_hs -- memory stage of the swt16 pipeline (between execute and
// writeback).
//
// Accepts one instruction at a time from execute. ALU-only instructions and
// misaligned word accesses are retired on the next cycle. Aligned loads and
// stores are latched and sent to a variable-latency data memory over a
// req/gnt/rvalid handshake. Upstream is stalled until the access completes.
// A watchdog aborts accesses that never complete.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   in_valid .. in_mem_wr_word
//                            instruction and operands from execute
//   out_stall                upstream must hold (state != IDLE)
//   out_dmem_req/we/addr/wdata/be
//                            memory request, held stable until in_dmem_gnt
//   in_dmem_gnt, in_dmem_rvalid, in_dmem_rdata
//                            memory grant and read response
//   out_valid .. out_pc      registered writeback bundle (one-cycle valid pulse)
//   out_misalign_err         word access with non-zero low address bits
//   out_timeout_err          access aborted by the watchdog
// out_misalign_err and out_timeout_err are meaningful only while out_valid is 1.

module mem_stage_hs #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int IALU_WORD_WIDTH = 16,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PC_WIDTH        = 12,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int TIMEOUT_WIDTH   = 8,
    localparam int NB             = DMEM_WORD_WIDTH / 8,
    localparam int LB             = $clog2(NB)
) (
    input  logic                         clock,
    input  logic                         reset,

    input  logic                         in_valid,
    input  logic                         in_act_load_dmem,
    input  logic                         in_act_store_dmem,
    input  logic                         in_size_byte,
    input  logic                         in_load_signed,
    input  logic                         in_act_write_res_to_reg,
    input  logic [PMEM_WORD_WIDTH-1:0]   in_instr,
    input  logic [PC_WIDTH-1:0]          in_pc,
    input  logic [IALU_WORD_WIDTH-1:0]   in_res,
    input  logic [REG_IDX_WIDTH-1:0]     in_res_reg_idx,
    input  logic [DMEM_ADDR_WIDTH-1:0]   in_mem_addr,
    input  logic [DMEM_WORD_WIDTH-1:0]   in_mem_wr_word,

    output logic                         out_stall,

    output logic                         out_dmem_req,
    output logic                         out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-LB-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0]   out_dmem_wdata,
    output logic [NB-1:0]                out_dmem_be,
    input  logic                         in_dmem_gnt,
    input  logic                         in_dmem_rvalid,
    input  logic [DMEM_WORD_WIDTH-1:0]   in_dmem_rdata,

    output logic                         out_valid,
    output logic                         out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0]   out_res,
    output logic [REG_IDX_WIDTH-1:0]     out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic                         out_misalign_err,
    output logic                         out_timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Access captured on acceptance; drives the request and the result.
    logic                         is_store_reg;
    logic                         size_byte_reg;
    logic                         load_signed_reg;
    logic                         wr_en_reg;
    logic [PMEM_WORD_WIDTH-1:0]   instr_reg;
    logic [PC_WIDTH-1:0]          pc_reg;
    logic [IALU_WORD_WIDTH-1:0]   res_reg;
    logic [REG_IDX_WIDTH-1:0]     idx_reg;
    logic [DMEM_ADDR_WIDTH-1:0]   addr_reg;
    logic [DMEM_WORD_WIDTH-1:0]   st_data_reg;

    logic [TIMEOUT_WIDTH-1:0]     wd_reg;
    logic [TIMEOUT_WIDTH-1:0]     wd_inc;

    // Registered writeback bundle.
    logic                         out_valid_reg;
    logic                         out_wr_reg;
    logic [IALU_WORD_WIDTH-1:0]   out_res_reg;
    logic [REG_IDX_WIDTH-1:0]     out_idx_reg;
    logic [PMEM_WORD_WIDTH-1:0]   out_instr_reg;
    logic [PC_WIDTH-1:0]          out_pc_reg;
    logic                         out_mis_reg;
    logic                         out_to_reg;

    // Control decoded in the next-state process.
    logic                         is_mem_op;
    logic                         is_misaligned;
    logic                         wd_expired;
    logic                         latch_en;
    logic                         out_en;
    logic                         out_from_in;
    logic [IALU_WORD_WIDTH-1:0]   res_next;
    logic                         wr_next;
    logic                         mis_next;
    logic                         to_next;

    // Byte-lane helpers.
    logic [LB-1:0]                lane_idx;
    logic [7:0]                   rd_lane [NB];
    logic [NB-1:0]                be_byte;
    logic [DMEM_WORD_WIDTH-1:0]   wdata_rep;
    logic [7:0]                   ld_byte;
    logic [DMEM_WORD_WIDTH-1:0]   ld_data;
    logic                         req_active;

    assign lane_idx = addr_reg[LB-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign rd_lane[gi]           = in_dmem_rdata[8*gi +: 8];
            assign be_byte[gi]           = (lane_idx == LB'(gi));
            assign wdata_rep[8*gi +: 8]  = st_data_reg[7:0];
        end
    endgenerate

    assign ld_byte = rd_lane[lane_idx];
    assign ld_data = size_byte_reg
                   ? {{(DMEM_WORD_WIDTH-8){load_signed_reg & ld_byte[7]}}, ld_byte}
                   : in_dmem_rdata;

    assign is_mem_op     = in_act_load_dmem | in_act_store_dmem;
    assign is_misaligned = !in_size_byte && (in_mem_addr[LB-1:0] != '0);

    // The access is abandoned on the edge at which the count would reach all
    // ones, so a never-granted request stays up for 2**TIMEOUT_WIDTH-1 cycles.
    assign wd_inc     = wd_reg + TIMEOUT_WIDTH'(1);
    assign wd_expired = (wd_inc == '1);

    always_comb begin
        state_next  = state_reg;
        latch_en    = 1'b0;
        out_en      = 1'b0;
        out_from_in = 1'b0;
        res_next    = res_reg;
        wr_next     = 1'b0;
        mis_next    = 1'b0;
        to_next     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem_op) begin
                        out_en      = 1'b1;
                        out_from_in = 1'b1;
                        res_next    = in_res;
                        wr_next     = in_act_write_res_to_reg;
                    end else if (is_misaligned) begin
                        out_en      = 1'b1;
                        out_from_in = 1'b1;
                        res_next    = in_res;
                        mis_next    = 1'b1;
                    end else begin
                        latch_en    = 1'b1;
                        state_next  = REQ;
                    end
                end
            end
            REQ: begin
                // A grant in the expiry cycle wins over the watchdog.
                if (in_dmem_gnt) begin
                    if (is_store_reg) begin
                        state_next = IDLE;
                        out_en     = 1'b1;
                        wr_next    = wr_en_reg;
                    end else begin
                        state_next = RESP;
                    end
                end else if (wd_expired) begin
                    state_next = IDLE;
                    out_en     = 1'b1;
                    to_next    = 1'b1;
                end
            end
            RESP: begin
                if (in_dmem_rvalid) begin
                    state_next = IDLE;
                    out_en     = 1'b1;
                    res_next   = ld_data;
                    wr_next    = wr_en_reg;
                end else if (wd_expired) begin
                    state_next = IDLE;
                    out_en     = 1'b1;
                    to_next    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                wd_reg <= '0;
            end else if (state_reg != IDLE) begin
                wd_reg <= wd_inc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_store_reg    <= 1'b0;
            size_byte_reg   <= 1'b0;
            load_signed_reg <= 1'b0;
            wr_en_reg       <= 1'b0;
            instr_reg       <= '0;
            pc_reg          <= '0;
            res_reg         <= '0;
            idx_reg         <= '0;
            addr_reg        <= '0;
            st_data_reg     <= '0;
        end else if (latch_en) begin
            // Load+store together behaves as a store.
            is_store_reg    <= in_act_store_dmem;
            size_byte_reg   <= in_size_byte;
            load_signed_reg <= in_load_signed;
            wr_en_reg       <= in_act_write_res_to_reg;
            instr_reg       <= in_instr;
            pc_reg          <= in_pc;
            res_reg         <= in_res;
            idx_reg         <= in_res_reg_idx;
            addr_reg        <= in_mem_addr;
            st_data_reg     <= in_mem_wr_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_wr_reg    <= 1'b0;
            out_res_reg   <= '0;
            out_idx_reg   <= '0;
            out_instr_reg <= '0;
            out_pc_reg    <= '0;
            out_mis_reg   <= 1'b0;
            out_to_reg    <= 1'b0;
        end else begin
            out_valid_reg <= out_en;
            // Bundle only changes on a retirement so it stays stable between pulses.
            if (out_en) begin
                out_wr_reg  <= wr_next;
                out_res_reg <= res_next;
                out_mis_reg <= mis_next;
                out_to_reg  <= to_next;
                if (out_from_in) begin
                    out_idx_reg   <= in_res_reg_idx;
                    out_instr_reg <= in_instr;
                    out_pc_reg    <= in_pc;
                end else begin
                    out_idx_reg   <= idx_reg;
                    out_instr_reg <= instr_reg;
                    out_pc_reg    <= pc_reg;
                end
            end
        end
    end

    assign req_active     = (state_reg == REQ);
    assign out_stall      = (state_reg != IDLE);
    assign out_dmem_req   = req_active;
    assign out_dmem_we    = req_active & is_store_reg;
    assign out_dmem_addr  = req_active ? addr_reg[DMEM_ADDR_WIDTH-1:LB] : '0;
    assign out_dmem_be    = !req_active ? '0 : (size_byte_reg ? be_byte : '1);
    assign out_dmem_wdata = !req_active ? '0 : (size_byte_reg ? wdata_rep : st_data_reg);

    assign out_valid                = out_valid_reg;
    assign out_act_write_res_to_reg = out_wr_reg;
    assign out_res                  = out_res_reg;
    assign out_res_reg_idx          = out_idx_reg;
    assign out_instr                = out_instr_reg;
    assign out_pc                   = out_pc_reg;
    assign out_misalign_err         = out_mis_reg;
    assign out_timeout_err          = out_to_reg;

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation memory stage of the swt16 pipeline, between execute and writeback.
- Talks to a variable-latency data memory over a req/gnt/rvalid handshake and stalls upstream while an access is outstanding.
- Supports byte and full-word accesses on a configurable word width, with sign/zero-extended byte loads.
- Flags misaligned word accesses and memory timeouts.

Parameters:
- DMEM_ADDR_WIDTH, 12: byte-address width of in_mem_addr.
- DMEM_WORD_WIDTH, 16: data word width; must be a power of two and at least 16. NB = DMEM_WORD_WIDTH/8 and LB = log2(NB).
- IALU_WORD_WIDTH, 16: width of the ALU result; equals DMEM_WORD_WIDTH.
- PMEM_WORD_WIDTH, 16: instruction width.
- PC_WIDTH, 12: program counter width.
- REG_IDX_WIDTH, 4: register index width.
- TIMEOUT_WIDTH, 8: width of the outstanding-access watchdog counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  execute stage presents an instruction.
- in_act_load_dmem  in  1  instruction is a load.
- in_act_store_dmem  in  1  instruction is a store.
- in_size_byte  in  1  1 = byte access, 0 = word access.
- in_load_signed  in  1  sign-extend byte loads.
- in_act_write_res_to_reg  in  1  writeback enable.
- in_instr  in  PMEM_WORD_WIDTH  instruction.
- in_pc  in  PC_WIDTH  program counter.
- in_res  in  IALU_WORD_WIDTH  ALU result.
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register.
- in_mem_addr  in  DMEM_ADDR_WIDTH  byte address.
- in_mem_wr_word  in  DMEM_WORD_WIDTH  store data (byte stores use bits [7:0]).
- out_stall  out  1  upstream must hold its inputs.
- out_dmem_req  out  1  memory request.
- out_dmem_we  out  1  1 = write.
- out_dmem_addr  out  DMEM_ADDR_WIDTH-LB  word address.
- out_dmem_wdata  out  DMEM_WORD_WIDTH  write data.
- out_dmem_be  out  NB  byte enables.
- in_dmem_gnt  in  1  request accepted.
- in_dmem_rvalid  in  1  read data valid.
- in_dmem_rdata  in  DMEM_WORD_WIDTH  read data.
- out_valid  out  1  one-cycle writeback pulse.
- out_act_write_res_to_reg  out  1  writeback enable.
- out_res  out  IALU_WORD_WIDTH  result.
- out_res_reg_idx  out  REG_IDX_WIDTH  destination register.
- out_instr  out  PMEM_WORD_WIDTH  instruction.
- out_pc  out  PC_WIDTH  program counter.
- out_misalign_err  out  1  misaligned word access flag.
- out_timeout_err  out  1  watchdog expiry flag.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE, watchdog clears, all registered outputs are 0. Consequently out_dmem_req, out_stall and out_valid drop immediately.
- A reset mid-access abandons the access. A later rvalid from the aborted access is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, no memory op (in_valid and neither load nor store):
  - Register the pass-through fields.
  - out_valid=1 next cycle with out_res=in_res.
  - Latency 1; no stall.
- IDLE, load or store, misaligned (word access with in_mem_addr[LB-1:0]!=0):
  - No request is issued.
  - Next cycle: out_valid=1, out_misalign_err=1, out_act_write_res_to_reg=0.
- IDLE, load or store, aligned: latch all inputs and go to REQ.
- out_stall = (state != IDLE).
- REQ:
  - out_dmem_req=1, driven from latched values and held stable until in_dmem_gnt.
  - out_dmem_addr = addr[DMEM_ADDR_WIDTH-1:LB].
  - Word access: be = all ones, wdata = store data.
  - Byte access: be = 1 << addr[LB-1:0], wdata = byte [7:0] replicated NB times.
- REQ + gnt, store: go to IDLE; out_valid=1 next cycle with out_act_write_res_to_reg as latched.
- REQ + gnt, load: go to RESP.
- RESP: in_dmem_rvalid is sampled only here, so rvalid is legal no earlier than the cycle after gnt.
- RESP + rvalid: go to IDLE; out_valid=1 next cycle.
  - Word load: out_res = rdata.
  - Byte load: lane = rdata[8*k+7:8*k] with k = addr[LB-1:0], then sign- or zero-extended per in_load_signed.
- Watchdog:
  - Clears on entering REQ and increments each cycle in REQ or RESP.
  - At all ones the access is aborted: out_dmem_req drops, FSM goes to IDLE.
  - Next cycle: out_valid=1, out_timeout_err=1, out_act_write_res_to_reg=0.
  - A gnt or rvalid arriving in the expiry cycle takes priority over the timeout.
- Outputs are held stable between out_valid pulses. The error flags are valid only with out_valid.
- in_valid with both load and store set is treated as a store.

Test Plan:
- ALU op: in_res=0x1234, reg idx 5 -> next cycle out_valid=1, out_res=0x1234, idx 5, out_stall never asserts.
- Byte store: addr 0x003, data 0x00AB, gnt after 2 cycles -> req held 3 cycles, out_dmem_addr=0x001, be=2'b10, wdata=0xABAB; out_stall high for 3 cycles; out_valid follows gnt by 1 cycle.
- Signed byte load: addr 0x002, rdata 0x7F80, rvalid 3 cycles after gnt -> out_res=0xFF80; unsigned -> 0x0080; high-lane address 0x003 -> 0x007F.
- Misaligned word load at 0x005 -> no req; next cycle out_valid=1, out_misalign_err=1, writeback disabled.
- Timeout: gnt never arrives -> req drops after 255 cycles; out_valid with out_timeout_err=1. Second run: reset asserted mid-RESP -> outputs 0 immediately, late rvalid ignored.
